regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter.sv | 139 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Three-requester register-file write-back arbiter: up to two non-zero writes per cycle
// onto ports a/b with round-robin priority, plus free acceptance of writes to x0.
module regfile_wb_arbiter #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            resetb_i,
  input  logic            clk_en_i,
  input  logic            req_0_valid_i,
  input  logic [4:0]      req_0_addr_i,
  input  logic [XLEN-1:0] req_0_data_i,
  output logic            req_0_ready_o,
  input  logic            req_1_valid_i,
  input  logic [4:0]      req_1_addr_i,
  input  logic [XLEN-1:0] req_1_data_i,
  output logic            req_1_ready_o,
  input  logic            req_2_valid_i,
  input  logic [4:0]      req_2_addr_i,
  input  logic [XLEN-1:0] req_2_data_i,
  output logic            req_2_ready_o,
  output logic            wreg_a_wr_o,
  output logic [4:0]      wreg_a_addr_o,
  output logic [XLEN-1:0] wreg_a_data_o,
  output logic            wreg_b_wr_o,
  output logic [4:0]      wreg_b_addr_o,
  output logic [XLEN-1:0] wreg_b_data_o,
  output logic [1:0]      rr_ptr_o
);

  localparam int NREQ = 3;

  logic [NREQ-1:0] req_valid;
  logic [4:0]      req_addr [NREQ];
  logic [XLEN-1:0] req_data [NREQ];

  assign req_valid   = {req_2_valid_i, req_1_valid_i, req_0_valid_i};
  assign req_addr[0] = req_0_addr_i;
  assign req_addr[1] = req_1_addr_i;
  assign req_addr[2] = req_2_addr_i;
  assign req_data[0] = req_0_data_i;
  assign req_data[1] = req_1_data_i;
  assign req_data[2] = req_2_data_i;

  function automatic logic [1:0] mod3(input logic [2:0] v);
    case (v)
      3'd0:    return 2'd0;
      3'd1:    return 2'd1;
      3'd2:    return 2'd2;
      3'd3:    return 2'd0;
      3'd4:    return 2'd1;
      default: return 2'd0;
    endcase
  endfunction

  logic [1:0]      rr_ptr_p1;
  logic [1:0]      head_p0;
  logic [1:0]      idx_p0;
  logic [1:0]      last_idx_p0;
  logic [NREQ-1:0] ready_p0;
  logic            vld_a_p0, vld_b_p0;
  logic [4:0]      addr_a_p0, addr_b_p0;
  logic [XLEN-1:0] data_a_p0, data_b_p0;

  // p0: combinational priority scan; a fault value of 3 in the pointer is treated as 0
  always_comb begin
    head_p0     = (rr_ptr_p1 == 2'd3) ? 2'd0 : rr_ptr_p1;
    idx_p0      = 2'd0;
    last_idx_p0 = head_p0;
    ready_p0    = '0;
    vld_a_p0    = 1'b0;
    vld_b_p0    = 1'b0;
    addr_a_p0   = '0;
    addr_b_p0   = '0;
    data_a_p0   = '0;
    data_b_p0   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx_p0 = mod3({1'b0, head_p0} + 3'(k));
      if (resetb_i && clk_en_i && req_valid[idx_p0]) begin
        if (req_addr[idx_p0] == 5'd0) begin
          ready_p0[idx_p0] = 1'b1;
        end else if (!vld_a_p0) begin
          ready_p0[idx_p0] = 1'b1;
          vld_a_p0         = 1'b1;
          addr_a_p0        = req_addr[idx_p0];
          data_a_p0        = req_data[idx_p0];
          last_idx_p0      = idx_p0;
        end else if (!vld_b_p0 && (req_addr[idx_p0] != addr_a_p0)) begin
          ready_p0[idx_p0] = 1'b1;
          vld_b_p0         = 1'b1;
          addr_b_p0        = req_addr[idx_p0];
          data_b_p0        = req_data[idx_p0];
          last_idx_p0      = idx_p0;
        end
      end
    end
  end

  assign req_0_ready_o = ready_p0[0];
  assign req_1_ready_o = ready_p0[1];
  assign req_2_ready_o = ready_p0[2];

  logic            vld_a_p1, vld_b_p1;
  logic [4:0]      addr_a_p1, addr_b_p1;
  logic [XLEN-1:0] data_a_p1, data_b_p1;

  // p1: registered write-back ports and round-robin pointer
  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      vld_a_p1  <= 1'b0;
      vld_b_p1  <= 1'b0;
      addr_a_p1 <= '0;
      addr_b_p1 <= '0;
      data_a_p1 <= '0;
      data_b_p1 <= '0;
      rr_ptr_p1 <= 2'd0;
    end else if (clk_en_i) begin
      vld_a_p1 <= vld_a_p0;
      vld_b_p1 <= vld_b_p0;
      if (vld_a_p0) begin
        addr_a_p1 <= addr_a_p0;
        data_a_p1 <= data_a_p0;
        rr_ptr_p1 <= mod3({1'b0, last_idx_p0} + 3'd1);
      end
      if (vld_b_p0) begin
        addr_b_p1 <= addr_b_p0;
        data_b_p1 <= data_b_p0;
      end
    end
  end

  assign wreg_a_wr_o   = vld_a_p1;
  assign wreg_a_addr_o = addr_a_p1;
  assign wreg_a_data_o = data_a_p1;
  assign wreg_b_wr_o   = vld_b_p1;
  assign wreg_b_addr_o = addr_b_p1;
  assign wreg_b_data_o = data_b_p1;
  assign rr_ptr_o      = rr_ptr_p1;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: hand-computed grants, port contents and pointer.
module tb_regfile_wb_arbiter;

  localparam int XLEN = 32;

  logic            clk_i = 1'b0;
  logic            resetb_i;
  logic            clk_en_i;
  logic            r0_v, r1_v, r2_v;
  logic [4:0]      r0_a, r1_a, r2_a;
  logic [XLEN-1:0] r0_d, r1_d, r2_d;
  logic            r0_rdy, r1_rdy, r2_rdy;
  logic            a_wr, b_wr;
  logic [4:0]      a_addr, b_addr;
  logic [XLEN-1:0] a_data, b_data;
  logic [1:0]      rr_ptr;

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  regfile_wb_arbiter #(.XLEN(XLEN)) dut (
    .clk_i         (clk_i),
    .resetb_i      (resetb_i),
    .clk_en_i      (clk_en_i),
    .req_0_valid_i (r0_v),
    .req_0_addr_i  (r0_a),
    .req_0_data_i  (r0_d),
    .req_0_ready_o (r0_rdy),
    .req_1_valid_i (r1_v),
    .req_1_addr_i  (r1_a),
    .req_1_data_i  (r1_d),
    .req_1_ready_o (r1_rdy),
    .req_2_valid_i (r2_v),
    .req_2_addr_i  (r2_a),
    .req_2_data_i  (r2_d),
    .req_2_ready_o (r2_rdy),
    .wreg_a_wr_o   (a_wr),
    .wreg_a_addr_o (a_addr),
    .wreg_a_data_o (a_data),
    .wreg_b_wr_o   (b_wr),
    .wreg_b_addr_o (b_addr),
    .wreg_b_data_o (b_data),
    .rr_ptr_o      (rr_ptr)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int n, input logic v, input logic [4:0] a, input logic [XLEN-1:0] d);
    case (n)
      0: begin r0_v = v; r0_a = a; r0_d = d; end
      1: begin r1_v = v; r1_a = a; r1_d = d; end
      default: begin r2_v = v; r2_a = a; r2_d = d; end
    endcase
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_port_a(input string tag, input logic wr, input logic [4:0] ad, input logic [XLEN-1:0] d);
    chk({tag, ".a_wr"}, 64'(a_wr), 64'(wr));
    chk({tag, ".a_addr"}, 64'(a_addr), 64'(ad));
    chk({tag, ".a_data"}, 64'(a_data), 64'(d));
  endtask

  task automatic chk_port_b(input string tag, input logic wr, input logic [4:0] ad, input logic [XLEN-1:0] d);
    chk({tag, ".b_wr"}, 64'(b_wr), 64'(wr));
    chk({tag, ".b_addr"}, 64'(b_addr), 64'(ad));
    chk({tag, ".b_data"}, 64'(b_data), 64'(d));
  endtask

  initial begin
    resetb_i = 1'b0;
    clk_en_i = 1'b1;
    set_req(0, 1'b1, 5'd5, 32'h1);
    set_req(1, 1'b1, 5'd6, 32'h2);
    set_req(2, 1'b1, 5'd7, 32'h3);
    #3;
    chk("rst.ready", 64'({r2_rdy, r1_rdy, r0_rdy}), 64'b000);
    chk_port_a("rst", 1'b0, 5'd0, '0);
    chk_port_b("rst", 1'b0, 5'd0, '0);
    chk("rst.rr", 64'(rr_ptr), 64'd0);
    step();
    chk("rst_edge.a_wr", 64'(a_wr), 64'd0);
    resetb_i = 1'b1;

    // three distinct addresses from head 0
    set_req(0, 1'b1, 5'd5, 32'hA0);
    set_req(1, 1'b1, 5'd6, 32'hA1);
    set_req(2, 1'b1, 5'd7, 32'hA2);
    #1;
    chk("t1.ready", 64'({r2_rdy, r1_rdy, r0_rdy}), 64'b011);
    step();
    set_req(0, 1'b0, 5'd0, '0);
    set_req(1, 1'b0, 5'd0, '0);
    #1;
    chk_port_a("t1c1", 1'b1, 5'd5, 32'hA0);
    chk_port_b("t1c1", 1'b1, 5'd6, 32'hA1);
    chk("t1c1.rr", 64'(rr_ptr), 64'd2);
    chk("t1c1.ready", 64'({r2_rdy, r1_rdy, r0_rdy}), 64'b100);
    step();
    set_req(2, 1'b0, 5'd0, '0);
    chk_port_a("t1c2", 1'b1, 5'd7, 32'hA2);
    chk_port_b("t1c2", 1'b0, 5'd6, 32'hA1);
    chk("t1c2.rr", 64'(rr_ptr), 64'd0);
    step();
    chk_port_a("t1idle", 1'b0, 5'd7, 32'hA2);
    chk("t1idle.rr", 64'(rr_ptr), 64'd0);

    // same-address conflict: req1 waits, req2 takes port b
    set_req(0, 1'b1, 5'd9, 32'h11);
    set_req(1, 1'b1, 5'd9, 32'h22);
    set_req(2, 1'b1, 5'd3, 32'h33);
    #1;
    chk("t2.ready", 64'({r2_rdy, r1_rdy, r0_rdy}), 64'b101);
    step();
    set_req(0, 1'b0, 5'd0, '0);
    set_req(2, 1'b0, 5'd0, '0);
    #1;
    chk_port_a("t2c1", 1'b1, 5'd9, 32'h11);
    chk_port_b("t2c1", 1'b1, 5'd3, 32'h33);
    chk("t2c1.rr", 64'(rr_ptr), 64'd0);
    chk("t2c1.ready", 64'({r2_rdy, r1_rdy, r0_rdy}), 64'b010);
    step();
    set_req(1, 1'b0, 5'd0, '0);
    chk_port_a("t2c2", 1'b1, 5'd9, 32'h22);
    chk("t2c2.b_wr", 64'(b_wr), 64'd0);
    chk("t2c2.rr", 64'(rr_ptr), 64'd2);

    // x0 writes: always accepted, no strobe, pointer untouched
    set_req(1, 1'b1, 5'd0, 32'hDEAD);
    #1;
    chk("t3a.ready", 64'({r2_rdy, r1_rdy, r0_rdy}), 64'b010);
    step();
    chk("t3a.a_wr", 64'(a_wr), 64'd0);
    chk("t3a.b_wr", 64'(b_wr), 64'd0);
    chk("t3a.rr", 64'(rr_ptr), 64'd2);
    set_req(2, 1'b1, 5'd1, 32'h01);
    #1;
    chk("t3b.ready", 64'({r2_rdy, r1_rdy, r0_rdy}), 64'b110);
    step();
    set_req(2, 1'b0, 5'd0, '0);
    chk_port_a("t3b", 1'b1, 5'd1, 32'h01);
    chk("t3b.rr", 64'(rr_ptr), 64'd0);
    set_req(0, 1'b1, 5'd4, 32'h44);
    set_req(2, 1'b1, 5'd8, 32'h88);
    #1;
    chk("t3c.ready", 64'({r2_rdy, r1_rdy, r0_rdy}), 64'b111);
    step();
    set_req(0, 1'b0, 5'd0, '0);
    set_req(1, 1'b0, 5'd0, '0);
    set_req(2, 1'b0, 5'd0, '0);
    chk_port_a("t3c", 1'b1, 5'd4, 32'h44);
    chk_port_b("t3c", 1'b1, 5'd8, 32'h88);
    chk("t3c.rr", 64'(rr_ptr), 64'd0);

    // clock enable low: everything frozen for three cycles
    clk_en_i = 1'b0;
    set_req(0, 1'b1, 5'd11, 32'hB0);
    set_req(1, 1'b1, 5'd12, 32'hB1);
    set_req(2, 1'b1, 5'd13, 32'hB2);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t4.ready", 64'({r2_rdy, r1_rdy, r0_rdy}), 64'b000);
      step();
      chk("t4.a_wr", 64'(a_wr), 64'd1);
      chk("t4.a_addr", 64'(a_addr), 64'd4);
      chk("t4.b_wr", 64'(b_wr), 64'd1);
      chk("t4.b_addr", 64'(b_addr), 64'd8);
      chk("t4.rr", 64'(rr_ptr), 64'd0);
    end
    clk_en_i = 1'b1;
    #1;
    chk("t4r.ready", 64'({r2_rdy, r1_rdy, r0_rdy}), 64'b011);
    step();
    set_req(0, 1'b0, 5'd0, '0);
    set_req(1, 1'b0, 5'd0, '0);
    chk_port_a("t4r1", 1'b1, 5'd11, 32'hB0);
    chk_port_b("t4r1", 1'b1, 5'd12, 32'hB1);
    chk("t4r1.rr", 64'(rr_ptr), 64'd2);
    step();
    set_req(2, 1'b0, 5'd0, '0);
    chk_port_a("t4r2", 1'b1, 5'd13, 32'hB2);
    chk("t4r2.rr", 64'(rr_ptr), 64'd0);

    // asynchronous reset while port a strobe is high
    set_req(0, 1'b1, 5'd20, 32'hC0);
    step();
    set_req(0, 1'b1, 5'd21, 32'hC1);
    set_req(2, 1'b1, 5'd21, 32'hC2);
    chk("t5pre.a_wr", 64'(a_wr), 64'd1);
    chk("t5pre.rr", 64'(rr_ptr), 64'd1);
    #2;
    resetb_i = 1'b0;
    #1;
    chk_port_a("t5rst", 1'b0, 5'd0, '0);
    chk_port_b("t5rst", 1'b0, 5'd0, '0);
    chk("t5rst.rr", 64'(rr_ptr), 64'd0);
    chk("t5rst.ready", 64'({r2_rdy, r1_rdy, r0_rdy}), 64'b000);
    step();
    chk("t5hold.a_wr", 64'(a_wr), 64'd0);
    resetb_i = 1'b1;
    #1;
    chk("t5post.ready", 64'({r2_rdy, r1_rdy, r0_rdy}), 64'b001);
    step();
    set_req(0, 1'b0, 5'd0, '0);
    #1;
    chk_port_a("t5post", 1'b1, 5'd21, 32'hC1);
    chk("t5post.rr", 64'(rr_ptr), 64'd1);
    chk("t5post2.ready", 64'({r2_rdy, r1_rdy, r0_rdy}), 64'b100);
    step();
    set_req(2, 1'b0, 5'd0, '0);
    chk_port_a("t5post2", 1'b1, 5'd21, 32'hC2);
    chk("t5post2.rr", 64'(rr_ptr), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
